mp_add_seq: RTL and testbench
=============================

Name: mp_add_seq

Overview:
- Word-serial multi-precision adder front/back end for the 16-bit Sklansky prefix adder core (ports A, B, Cin, S, Cout).
- Accepts operand pairs as a valid/ready stream of 16-bit limbs, least-significant first. Feeds each limb pair to one adder instance and chains the carry across beats in a register.
- Emits registered sum limbs with last-beat carry-out and signed-overflow flags.
- Sits between the operand fetch/buffer logic and the result writeback stream.

Parameters:
- MAX_WORDS, 16, maximum limbs per operand; a longer packet is force-terminated.
- CNT_W, $clog2(MAX_WORDS+1), width of the beat counter.

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset; synchronous, active-high
- cin_init  in  1  carry into limb 0; sampled on the first beat of a packet
- in_valid  in  1  limb pair valid
- in_ready  out  1  block can accept a limb pair
- in_a  in  16  operand A limb
- in_b  in  16  operand B limb
- in_last  in  1  most-significant limb of the packet
- out_valid  out  1  sum limb valid
- out_ready  in  1  downstream accepts the sum limb
- out_sum  out  16  sum limb
- out_last  out  1  final limb of the packet
- out_cout  out  1  carry-out of the MS limb; valid only when out_last=1, 0 otherwise
- out_ovf  out  1  signed overflow of the MS limb; valid only when out_last=1, 0 otherwise
- out_trunc  out  1  packet force-terminated at MAX_WORDS; valid with out_last

Behaviour:
- Reset values: out_valid=0, out_sum=0, out_last=0, out_cout=0, out_ovf=0, out_trunc=0, carry register=0, beat count=0, state=FIRST.
- Handshake:
  - in_ready = !out_valid || out_ready (single output register, no skid buffer).
  - Input transfer: in_valid && in_ready.
  - Output transfer: out_valid && out_ready.
  - out_* signals stay stable while out_valid && !out_ready.
- Latency: 1 cycle from input transfer to out_valid. Full throughput of 1 limb/cycle when out_ready is held high.
- Adder Cin is cin_init in FIRST state and the carry register in MID state.
- FSM states:
  - FIRST: on input transfer, register S; carry reg <= Cout; count <= 1. Go to MID unless the beat is last.
  - MID: on input transfer, same datapath; count increments. A last beat returns to FIRST.
- Last beat is in_last=1 or count==MAX_WORDS-1. On a last beat:
  - out_last=1 and out_cout=Cout.
  - out_ovf = (a[15]==b[15]) && (S[15]!=a[15]).
  - out_trunc=1 iff in_last=0.
  - Carry register cleared; count <= 0.
- out_ovf, out_cout and out_trunc are forced to 0 on non-last beats.
- Single-limb packet (in_last on first beat): completes in FIRST; cin_init is used and the state stays FIRST.
- Simultaneous output transfer and input transfer in the same cycle: new limb is registered with no bubble.
- in_valid deasserted mid-packet: state and carry are held indefinitely.
- rst mid-packet: partial packet discarded; next input transfer is treated as a first beat.
- MAX_WORDS=1: every beat is last.

Optional Feature:
- Macro MP_ADD_SUB_EN.
- Defined:
  - Adds input port sub (1 bit), sampled on the first beat and latched for the packet.
  - When sub=1: B limb fed to the adder is ~in_b, and first-beat Cin is 1, ignoring cin_init. Result is A-B.
  - out_cout=1 means no borrow.
  - out_ovf uses the inverted B sign.
- Undefined: port absent; pure addition only.

Decomposition:
- Shared package mp_add_pkg:
  - LIMB_W=16
  - state enum {FIRST, MID}
  - limb typedef logic [LIMB_W-1:0]
- One natural sub-module: mp_add_ctrl, holding the FSM, beat counter and last/truncate decode.
- Datapath, carry register and output register stay in the top module with the Sklansky adder instance.

Test Plan:
- Single-beat packet: A=0xFFFF, B=0x0001, cin_init=0, in_last=1 -> one output: sum=0x0000, last=1, cout=1, ovf=0.
- 3-limb packet:
  - Stimulus: A=0x0000_FFFF_FFFF, B=0x0000_0000_0001, cin_init=0.
  - Expected sums 0x0000, 0x0000, 0x0001 on consecutive cycles; cout=0.
  - Checks carry chaining with out_ready=1 at 1 beat/cycle.
- Backpressure: hold out_ready=0 for 4 cycles mid-packet -> in_ready=0, out_sum/out_last stable, no limb lost; values correct after release.
- Overflow: single beat A=0x7FFF, B=0x0001 -> sum=0x8000, ovf=1, cout=0.
- Truncation: MAX_WORDS=4, send 5 beats with in_last only on beat 5:
  - Beat 4 output: last=1, trunc=1.
  - Beat 5 handled as a new packet using cin_init.
- Reset mid-packet: rst after beat 2 of a carry-generating packet -> outputs cleared; next beat uses cin_init, not the stale carry.
- With MP_ADD_SUB_EN: sub=1, A=0x0005, B=0x0007 -> sum=0xFFFE, cout=0 (borrow).

Source files
------------

// File: rtl/mp_add_pkg.sv
// Shared types for the word-serial multi-precision adder.
package mp_add_pkg;
  localparam int LIMB_W = 16;

  typedef enum logic {FIRST, MID} state_t;

  typedef logic [LIMB_W-1:0] limb_t;
endpackage

// File: rtl/mp_add_ctrl.sv
// Packet FSM, beat counter and last/truncate decode for mp_add_seq.
module mp_add_ctrl import mp_add_pkg::*; #(
  parameter int MAX_WORDS = 16,
  parameter int CNT_W     = $clog2(MAX_WORDS + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic fire,
  input  logic in_last,
  output logic first,
  output logic last_beat,
  output logic trunc
);
  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign first     = (state_q == FIRST);
  assign last_beat = in_last || (cnt_q == CNT_W'(MAX_WORDS - 1));
  assign trunc     = last_beat && !in_last;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= FIRST;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (fire) begin
      if (last_beat) begin
        state_d = FIRST;
        cnt_d   = '0;
      end else begin
        state_d = MID;
        cnt_d   = cnt_q + CNT_W'(1);
      end
    end
  end
endmodule

// File: rtl/sklansky16.sv
// 16-bit Sklansky parallel-prefix adder core.
module sklansky16 import mp_add_pkg::*; (
  input  logic [LIMB_W-1:0] A,
  input  logic [LIMB_W-1:0] B,
  input  logic              Cin,
  output logic [LIMB_W-1:0] S,
  output logic              Cout
);
  localparam int unsigned LEVELS = $clog2(LIMB_W);

  always_comb begin
    logic [LIMB_W-1:0] hp, g, p, gn, pn;
    int unsigned j;
    hp = A ^ B;
    g  = A & B;
    p  = hp;
    // Cin folded into bit 0 generate so every prefix carries it forward
    g[0] = g[0] | (hp[0] & Cin);
    for (int unsigned l = 0; l < LEVELS; l++) begin
      gn = g;
      pn = p;
      for (int unsigned i = 0; i < LIMB_W; i++) begin
        if (((i >> l) & 1) == 1) begin
          j = ((i >> l) << l) - 1;
          gn[i[3:0]] = g[i[3:0]] | (p[i[3:0]] & g[j[3:0]]);
          pn[i[3:0]] = p[i[3:0]] & p[j[3:0]];
        end
      end
      g = gn;
      p = pn;
    end
    S    = hp ^ {g[LIMB_W-2:0], Cin};
    Cout = g[LIMB_W-1];
  end
endmodule

// File: rtl/mp_add_seq.sv
// Word-serial multi-precision adder around a Sklansky core; carry chained across limbs.
// Optional subtract mode when MP_ADD_SUB_EN is defined (adds port sub).
module mp_add_seq import mp_add_pkg::*; #(
  parameter int MAX_WORDS = 16,
  parameter int CNT_W     = $clog2(MAX_WORDS + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cin_init,
`ifdef MP_ADD_SUB_EN
  input  logic              sub,
`endif
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [LIMB_W-1:0] in_a,
  input  logic [LIMB_W-1:0] in_b,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [LIMB_W-1:0] out_sum,
  output logic              out_last,
  output logic              out_cout,
  output logic              out_ovf,
  output logic              out_trunc
);
  logic  fire, first, last_beat, trunc;
  logic  carry_q, add_cin, add_cout, b_inv;
  limb_t add_b, add_s;

  assign in_ready = !out_valid || out_ready;
  assign fire     = in_valid && in_ready;

`ifdef MP_ADD_SUB_EN
  logic sub_q;
  assign b_inv   = first ? sub : sub_q;
  // Subtraction forces the first-beat carry to 1 (two's complement of B)
  assign add_cin = first ? (sub | cin_init) : carry_q;

  always_ff @(posedge clk) begin
    if (rst)
      sub_q <= 1'b0;
    else if (fire && first)
      sub_q <= sub;
  end
`else
  assign b_inv   = 1'b0;
  assign add_cin = first ? cin_init : carry_q;
`endif

  assign add_b = b_inv ? ~in_b : in_b;

  mp_add_ctrl #(
    .MAX_WORDS(MAX_WORDS),
    .CNT_W    (CNT_W)
  ) u_ctrl (
    .clk      (clk),
    .rst      (rst),
    .fire     (fire),
    .in_last  (in_last),
    .first    (first),
    .last_beat(last_beat),
    .trunc    (trunc)
  );

  sklansky16 u_add (
    .A   (in_a),
    .B   (add_b),
    .Cin (add_cin),
    .S   (add_s),
    .Cout(add_cout)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_last  <= 1'b0;
      out_cout  <= 1'b0;
      out_ovf   <= 1'b0;
      out_trunc <= 1'b0;
      carry_q   <= 1'b0;
    end else if (fire) begin
      out_valid <= 1'b1;
      out_sum   <= add_s;
      out_last  <= last_beat;
      out_cout  <= last_beat & add_cout;
      out_ovf   <= last_beat & (in_a[LIMB_W-1] == add_b[LIMB_W-1])
                             & (add_s[LIMB_W-1] != in_a[LIMB_W-1]);
      out_trunc <= trunc;
      carry_q   <= last_beat ? 1'b0 : add_cout;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_mp_add_seq.sv
// Scoreboard bench for mp_add_seq: integer-arithmetic reference model, queue + monitor.
module tb_mp_add_seq;
  localparam int MW = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cin_init = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_a = '0;
  logic [15:0] in_b = '0;
  logic        in_last = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] out_sum;
  logic        out_last, out_cout, out_ovf, out_trunc;
`ifdef MP_ADD_SUB_EN
  logic        sub = 1'b0;
`endif

  always #5 clk = ~clk;

  mp_add_seq #(.MAX_WORDS(MW)) dut (
    .clk      (clk),
    .rst      (rst),
    .cin_init (cin_init),
`ifdef MP_ADD_SUB_EN
    .sub      (sub),
`endif
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_a     (in_a),
    .in_b     (in_b),
    .in_last  (in_last),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_sum  (out_sum),
    .out_last (out_last),
    .out_cout (out_cout),
    .out_ovf  (out_ovf),
    .out_trunc(out_trunc)
  );

  typedef struct packed {
    logic [15:0] sum;
    logic        last, cout, ovf, trunc;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   n_out = 0;
  int   pkt_beat = 0;
  int   carry_m = 0;
  bit   sub_m = 0;
  int   stall_left = 0;
  bit   rand_ready = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: compares the presented limb with the scoreboard head; pops on transfer
  always @(negedge clk) begin
    if (!rst && out_valid) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output: got sum %h with empty scoreboard", out_sum);
      end else begin
        check("sum",   32'(out_sum),   32'(q[0].sum));
        check("last",  32'(out_last),  32'(q[0].last));
        check("cout",  32'(out_cout),  32'(q[0].cout));
        check("ovf",   32'(out_ovf),   32'(q[0].ovf));
        check("trunc", 32'(out_trunc), 32'(q[0].trunc));
        if (out_ready) begin
          void'(q.pop_front());
          n_out++;
        end else begin
          check("in_ready_stall", 32'(in_ready), 32'd0);
        end
      end
    end
  end

  // Reference: packet boundaries by in_last or MW beats, limb sums by integer arithmetic
  task automatic model_accept(input logic [15:0] a, input logic [15:0] b,
                              input bit last, input bit cin, input bit sb);
    exp_t        e;
    bit          first_b, fin;
    logic [15:0] bb;
    int          c_in, sum_u, sv;
    first_b = (pkt_beat == 0);
    if (first_b) sub_m = sb;
`ifdef MP_ADD_SUB_EN
    bb   = sub_m ? ~b : b;
    c_in = first_b ? (sub_m ? 1 : int'(cin)) : carry_m;
`else
    bb   = b;
    c_in = first_b ? int'(cin) : carry_m;
`endif
    sum_u = int'(a) + int'(bb) + c_in;
    sv    = int'($signed(a)) + int'($signed(bb)) + c_in;
    fin   = last || (pkt_beat + 1 == MW);
    e.sum   = sum_u[15:0];
    e.last  = fin;
    e.cout  = fin && (sum_u > 65535);
    e.ovf   = fin && (sv > 32767 || sv < -32768);
    e.trunc = fin && !last;
    if (fin) begin
      pkt_beat = 0;
      carry_m  = 0;
    end else begin
      pkt_beat++;
      carry_m = (sum_u > 65535) ? 1 : 0;
    end
    q.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    if (stall_left > 0) begin
      out_ready = 1'b0;
      stall_left--;
    end else begin
      out_ready = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
    end
  endtask

  task automatic send(input logic [15:0] a, input logic [15:0] b,
                      input bit last, input bit cin, input bit sb);
    bit accepted = 0;
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    in_last  = last;
    cin_init = cin;
`ifdef MP_ADD_SUB_EN
    sub = sb;
`endif
    for (int t = 0; t < 100 && !accepted; t++) begin
      @(negedge clk);
      if (in_ready) begin
        model_accept(a, b, last, cin, sb);
        accepted = 1;
      end
      step();
    end
    if (!accepted) check("in_ready_timeout", 32'd0, 32'd1);
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) step();
  endtask

  task automatic drain();
    in_valid = 1'b0;
    for (int t = 0; t < 200 && q.size() > 0; t++) step();
    if (q.size() > 0) check("drain_timeout", 32'(q.size()), 32'd0);
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    rst      = 1'b1;
    q.delete();
    pkt_beat = 0;
    carry_m  = 0;
    step();
    step();
    rst = 1'b0;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_sum",   32'(out_sum),   32'd0);
    check("rst_out_flags", 32'({out_last, out_cout, out_ovf, out_trunc}), 32'd0);
  endtask

  initial begin
    int n0;
    do_reset();

    // single-limb carry out
    send(16'hFFFF, 16'h0001, 1, 0, 0);
    drain();

    // 3-limb carry chain at full rate
    n0 = n_out;
    send(16'hFFFF, 16'h0001, 0, 0, 0);
    send(16'hFFFF, 16'h0000, 0, 1, 0);
    send(16'h0000, 16'h0000, 1, 1, 0);
    idle(1);
    check("throughput_3beats", 32'(n_out - n0), 32'd3);
    drain();

    // backpressure mid-packet
    send(16'h8001, 16'h9000, 0, 0, 0);
    out_ready  = 1'b0;
    stall_left = 3;
    send(16'hFFFF, 16'h0002, 0, 0, 0);
    send(16'h1234, 16'h4321, 1, 0, 0);
    drain();

    // signed overflow on a single limb
    send(16'h7FFF, 16'h0001, 1, 0, 0);
    drain();

    // truncation at MW beats; the fifth beat opens a new packet with cin_init
    for (int i = 0; i < 4; i++) send(16'hFFFF, 16'h0000, 0, 1, 0);
    send(16'hFFFF, 16'h0000, 1, 0, 0);
    drain();

    // reset mid-packet discards the stale carry
    send(16'hFFFF, 16'h0001, 0, 0, 0);
    send(16'hFFFF, 16'h0000, 0, 0, 0);
    do_reset();
    send(16'h0000, 16'h0000, 1, 0, 0);
    drain();

`ifdef MP_ADD_SUB_EN
    send(16'h0005, 16'h0007, 1, 0, 1);
    drain();
    send(16'h0000, 16'h0001, 0, 0, 1);
    send(16'h0000, 16'h0000, 1, 0, 0);
    drain();
`endif

    // randomized packets under random backpressure
    rand_ready = 1;
    for (int i = 0; i < 400; i++) begin
      logic [15:0] a, b;
      a = 16'($urandom);
      b = 16'($urandom);
      case ($urandom_range(0, 5))
        0: a = 16'hFFFF;
        1: b = 16'h7FFF;
        default: ;
      endcase
      send(a, b, $urandom_range(0, 2) == 0, 1'($urandom), 1'($urandom));
      if ($urandom_range(0, 7) == 0) idle($urandom_range(1, 3));
    end
    rand_ready = 0;
    drain();
    idle(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
